// File: rtl/hub75_capture_if.sv
// HUB75 serial stream into the capture block and reconstructed pixel writes out of it.
interface hub75_capture_if #(
    parameter int columns  = 32,
    parameter int rows     = 8,
    parameter int bitwidth = 8
);
    localparam int aw = (rows > 1) ? $clog2(rows) : 1;
    localparam int cw = (columns > 1) ? $clog2(columns) : 1;

    logic                    oclk;
    logic                    lat;
    logic                    oe;
    logic [2:0]              rgb;
    logic [aw-1:0]           addr;
    logic                    wr_en;
    logic [aw-1:0]           wr_row;
    logic [cw-1:0]           wr_column;
    logic [3*bitwidth-1:0]   wr_pixel;
    logic                    row_done;
    logic [3:0]              err;

    modport master (
        output oclk, lat, oe, rgb, addr,
        input  wr_en, wr_row, wr_column, wr_pixel, row_done, err
    );

    modport slave (
        input  oclk, lat, oe, rgb, addr,
        output wr_en, wr_row, wr_column, wr_pixel, row_done, err
    );
endinterface

// File: rtl/hub75_capture.sv
// HUB75 stream receiver: shifts and latches column data, counts on-passes per
// pixel channel, then writes one reconstructed pixel per column for each row.
module hub75_capture #(
    parameter int columns  = 32,
    parameter int rows     = 8,
    parameter int bitwidth = 8
) (
    input  logic           clk,
    input  logic           rst,
    hub75_capture_if.slave bus
);
    localparam int aw   = (rows > 1) ? $clog2(rows) : 1;
    localparam int cw   = (columns > 1) ? $clog2(columns) : 1;
    localparam int scw  = $clog2(columns + 1);
    localparam int pw   = 3 * bitwidth;
    localparam int accw = bitwidth + 1;

    localparam logic [0:0] st_acc  = 1'b0;
    localparam logic [0:0] st_dump = 1'b1;

    localparam logic [scw-1:0]  shift_full  = scw'(columns);
    localparam logic [cw-1:0]   last_col    = cw'(columns - 1);
    localparam logic [accw-1:0] full_passes = {1'b1, {bitwidth{1'b0}}};

    logic [0:0]      state_reg;
    logic            oclk_prev_reg, lat_prev_reg, oe_prev_reg;
    logic [scw-1:0]  shift_cnt_reg, shift_cnt_next;
    logic [2:0]      shift_buf_reg  [columns];
    logic [2:0]      shift_buf_next [columns];
    logic [2:0]      latch_buf_reg  [columns];
    logic [pw-1:0]   sat_pix        [columns];
    logic [accw-1:0] pass_cnt_reg;
    logic [cw-1:0]   dump_col_reg;
    logic [aw-1:0]   row_addr_reg, lat_addr_reg;
    logic            wr_en_reg, row_done_reg;
    logic [aw-1:0]   wr_row_reg;
    logic [cw-1:0]   wr_column_reg;
    logic [pw-1:0]   wr_pixel_reg;
    logic [3:0]      err_reg;

    logic oclk_rise, lat_rise, oe_rise, oe_fall, shift_ok, row_abort, acc_step;

    function automatic logic [bitwidth-1:0] sat(input logic [accw-1:0] v);
        return v[bitwidth] ? '1 : v[bitwidth-1:0];
    endfunction

    assign oclk_rise = bus.oclk & ~oclk_prev_reg;
    assign lat_rise  = bus.lat & ~lat_prev_reg;
    assign oe_rise   = bus.oe & ~oe_prev_reg;
    assign oe_fall   = ~bus.oe & oe_prev_reg;

    assign shift_ok       = oclk_rise && (shift_cnt_reg != shift_full);
    assign shift_cnt_next = shift_ok ? shift_cnt_reg + scw'(1) : shift_cnt_reg;

    // A latch for a different row while passes are pending restarts accumulation.
    assign row_abort = lat_rise && (state_reg == st_acc) && (pass_cnt_reg != '0)
                       && (bus.addr != row_addr_reg);
    assign acc_step  = oe_rise && (state_reg == st_acc) && !row_abort
                       && (pass_cnt_reg != full_passes);

    generate
        for (genvar gi = 0; gi < columns; gi++) begin : g_col
            logic [accw-1:0] acc_r_reg, acc_g_reg, acc_b_reg;
            logic            col_clear;

            assign shift_buf_next[gi] = (shift_ok && shift_cnt_reg == scw'(gi))
                                        ? bus.rgb : shift_buf_reg[gi];
            assign col_clear = row_abort
                               || (state_reg == st_dump && dump_col_reg == cw'(gi));
            assign sat_pix[gi] = {sat(acc_r_reg), sat(acc_g_reg), sat(acc_b_reg)};

            always_ff @(posedge clk) begin
                if (rst || col_clear) begin
                    acc_r_reg <= '0;
                    acc_g_reg <= '0;
                    acc_b_reg <= '0;
                end else if (acc_step) begin
                    acc_r_reg <= acc_r_reg + accw'(latch_buf_reg[gi][2]);
                    acc_g_reg <= acc_g_reg + accw'(latch_buf_reg[gi][1]);
                    acc_b_reg <= acc_b_reg + accw'(latch_buf_reg[gi][0]);
                end
            end
        end
    endgenerate

    // The latch copies the post-shift buffer so a coincident oclk bit is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < columns; i++) begin
                shift_buf_reg[i] <= '0;
                latch_buf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < columns; i++) begin
                shift_buf_reg[i] <= shift_buf_next[i];
                if (lat_rise) latch_buf_reg[i] <= shift_buf_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= st_acc;
            oclk_prev_reg <= 1'b0;
            lat_prev_reg  <= 1'b0;
            oe_prev_reg   <= 1'b0;
            shift_cnt_reg <= '0;
            pass_cnt_reg  <= '0;
            dump_col_reg  <= '0;
            row_addr_reg  <= '0;
            lat_addr_reg  <= '0;
            wr_en_reg     <= 1'b0;
            row_done_reg  <= 1'b0;
            wr_row_reg    <= '0;
            wr_column_reg <= '0;
            wr_pixel_reg  <= '0;
            err_reg       <= '0;
        end else begin
            oclk_prev_reg <= bus.oclk;
            lat_prev_reg  <= bus.lat;
            oe_prev_reg   <= bus.oe;
            shift_cnt_reg <= lat_rise ? '0 : shift_cnt_next;
            wr_en_reg     <= 1'b0;
            row_done_reg  <= wr_en_reg && (wr_column_reg == last_col);

            if (oclk_rise && shift_cnt_reg == shift_full) err_reg[0] <= 1'b1;
            if (lat_rise) begin
                lat_addr_reg <= bus.addr;
                if (shift_cnt_next != shift_full) err_reg[1] <= 1'b1;
            end
            if (row_abort) err_reg[2] <= 1'b1;
            if (oe_rise && state_reg == st_dump) err_reg[3] <= 1'b1;

            case (state_reg)
                st_acc: begin
                    if (lat_rise && (pass_cnt_reg == '0 || row_abort))
                        row_addr_reg <= bus.addr;
                    if (row_abort)
                        pass_cnt_reg <= '0;
                    else if (acc_step)
                        pass_cnt_reg <= pass_cnt_reg + accw'(1);
                    if (oe_fall && pass_cnt_reg == full_passes && !row_abort) begin
                        state_reg    <= st_dump;
                        dump_col_reg <= '0;
                    end
                end
                default: begin
                    wr_en_reg     <= 1'b1;
                    wr_row_reg    <= row_addr_reg;
                    wr_column_reg <= dump_col_reg;
                    wr_pixel_reg  <= sat_pix[dump_col_reg];
                    dump_col_reg  <= dump_col_reg + cw'(1);
                    // A row latched during the dump becomes the next accumulation row.
                    if (dump_col_reg == last_col) begin
                        state_reg    <= st_acc;
                        pass_cnt_reg <= '0;
                        row_addr_reg <= lat_addr_reg;
                    end
                end
            endcase
        end
    end

    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_row    = wr_row_reg;
    assign bus.wr_column = wr_column_reg;
    assign bus.wr_pixel  = wr_pixel_reg;
    assign bus.row_done  = row_done_reg;
    assign bus.err       = err_reg;
endmodule
